// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: arbiter state encoding, HD44780 command bytes
// and default bus timing used by the init sequencer, display updater and arbiter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int unsigned DEF_SETUP_CYC = 32'd2;
  localparam int unsigned DEF_EN_CYC    = 32'd25;
  localparam int unsigned DEF_HOLD_CYC  = 32'd2;
  localparam int unsigned DEF_CMD_WAIT  = 32'd2000;
  localparam int unsigned DEF_LONG_WAIT = 32'd82000;

  // Home ignores bit 0, so 8'h03 is also a home command.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) &&
           ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable 32-bit down-counter; holds at zero and flags it.
module lcd_cycle_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_value,
  output logic        o_zero
);

  logic [31:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != 32'd0) begin
      r_count <= r_count - 32'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == 32'd0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter for two byte writers sharing one HD44780 8-bit bus,
// generating setup / EN pulse / hold / settle timing for each accepted byte.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC    = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned CMD_WAIT  = DEF_CMD_WAIT,
  parameter int unsigned LONG_WAIT = DEF_LONG_WAIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 32'd1);
  localparam logic [31:0] EN_LD    = 32'(EN_CYC - 32'd1);
  localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 32'd1);
  localparam logic [31:0] CMD_LD   = 32'(CMD_WAIT - 32'd1);
  localparam logic [31:0] LONG_LD  = 32'(LONG_WAIT - 32'd1);

  lcd_state_e  r_state;
  lcd_state_e  w_next;
  logic        r_last_grant;
  logic        r_lcd_en;
  logic        r_lcd_rs;
  logic [7:0]  r_lcd_data;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_value;
  logic        w_zero;

  lcd_cycle_timer u_timer (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_zero       (w_zero)
  );

  // On a tie the requester that did not win last time is served.
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept = (r_state == ST_IDLE) & (w_grant0 | w_grant1);

  // Next-state logic; the timer is reloaded on every state entry.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_value = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next       = ST_SETUP;
          w_load       = 1'b1;
          w_load_value = SETUP_LD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (w_zero) begin
          w_next       = ST_PULSE;
          w_load       = 1'b1;
          w_load_value = EN_LD;
        end else begin
          w_next = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (w_zero) begin
          w_next       = ST_HOLD;
          w_load       = 1'b1;
          w_load_value = HOLD_LD;
        end else begin
          w_next = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (w_zero) begin
          w_next       = ST_WAIT;
          w_load       = 1'b1;
          w_load_value = needs_long_wait(r_lcd_rs, r_lcd_data) ? LONG_LD : CMD_LD;
        end else begin
          w_next = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (w_zero) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_WAIT;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bus pins and grant history; EN is registered from next state so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcd_en     <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= 8'h00;
      r_last_grant <= 1'b1;
    end else begin
      r_lcd_en <= (w_next == ST_PULSE);
      if (w_accept) begin
        r_lcd_rs     <= w_grant0 ? req0_rs : req1_rs;
        r_lcd_data   <= w_grant0 ? req0_data : req1_data;
        r_last_grant <= w_grant1;
      end else begin
        r_lcd_rs     <= r_lcd_rs;
        r_lcd_data   <= r_lcd_data;
        r_last_grant <= r_last_grant;
      end
    end
  end

  assign req0_ready = w_accept & w_grant0;
  assign req1_ready = w_accept & w_grant1;
  assign lcd_en     = r_lcd_en;
  assign lcd_rs     = r_lcd_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = r_lcd_data;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_WAIT) & w_zero;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: a transfer-level model checked every cycle
// plus hand-computed timing expectations for each scenario.
module tb_lcd_bus_arbiter;

  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 2;
  localparam int C = 5;
  localparam int L = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, lcd_en, lcd_rs, lcd_rw, busy, done;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_errs   = 0;

  // model state
  int         m_k = 0;
  int         m_total = 0;
  logic       m_last = 1'b1;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         g_log[$];

  lcd_bus_arbiter #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .CMD_WAIT(C), .LONG_WAIT(L)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? L : C;
  endfunction

  // Transfer-level model: each accepted byte occupies cycles 1..total after its ready cycle.
  initial begin : compare
    logic e0, e1;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_k = 0; m_last = 1'b1; m_rs = 1'b0; m_data = 8'h00;
        chk_b("rst_en", lcd_en, 1'b0);
        chk_v("rst_data", int'(lcd_data), 0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
      end else begin
        chk_b("rw", lcd_rw, 1'b0);
        chk_b("rs", lcd_rs, m_rs);
        chk_v("data", int'(lcd_data), int'(m_data));
        if (m_k == 0) begin
          e0 = req0_valid && (!req1_valid || m_last);
          e1 = req1_valid && (!req0_valid || !m_last);
          chk_b("idle_busy", busy, 1'b0);
          chk_b("idle_en", lcd_en, 1'b0);
          chk_b("idle_done", done, 1'b0);
          chk_b("ready0", req0_ready, e0);
          chk_b("ready1", req1_ready, e1);
          if (e0 || e1) begin
            m_rs    = e0 ? req0_rs : req1_rs;
            m_data  = e0 ? req0_data : req1_data;
            m_last  = e1;
            m_total = S + E + H + wait_len(m_rs, m_data);
            m_k     = 1;
            g_log.push_back(e1 ? 1 : 0);
          end
        end else begin
          chk_b("busy", busy, 1'b1);
          chk_b("en", lcd_en, (m_k > S) && (m_k <= S + E));
          chk_b("done", done, m_k == m_total);
          chk_b("ready0_busy", req0_ready, 1'b0);
          chk_b("ready1_busy", req1_ready, 1'b0);
          m_k = (m_k == m_total) ? 0 : m_k + 1;
        end
      end
    end
  end

  function automatic logic rdy(input int idx);
    return (idx == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic drive(input int idx, input logic v, input logic rs, input logic [7:0] d);
    if (idx == 0) begin
      req0_valid = v; req0_rs = rs; req0_data = d;
    end else begin
      req1_valid = v; req1_rs = rs; req1_data = d;
    end
  endtask

  // Returns at #1 after the accept edge, i.e. inside cycle 1.
  task automatic wait_rdy(input int idx, input string nm);
    logic got;
    got = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      got = rdy(idx);
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    chk_b(nm, got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    logic idle;
    idle = 1'b0;
    for (int w = 0; w < 200 && !idle; w++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk_b(nm, idle, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int idx, input logic rs, input logic [7:0] d, input string nm,
                      output int t_en0, output int t_en1, output int n_en,
                      output int t_done, output int t_idle);
    drive(idx, 1'b1, rs, d);
    wait_rdy(idx, {nm, "_ready"});
    drive(idx, 1'b0, 1'b0, 8'h00);
    t_en0 = -1; t_en1 = -1; n_en = 0; t_done = -1; t_idle = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_b({nm, "_rs_c1"}, lcd_rs, rs);
        chk_v({nm, "_data_c1"}, int'(lcd_data), int'(d));
      end
      if (lcd_en) begin
        if (t_en0 < 0) t_en0 = c;
        t_en1 = c;
        n_en++;
      end
      if (done) t_done = c;
      if (!busy) begin
        t_idle = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input int idx, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      drive(idx, 1'b1, 1'b1, base + 8'(i));
      wait_rdy(idx, "t3_ready");
    end
    drive(idx, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin : main
    int t_en0, t_en1, n_en, t_done, t_idle, t_rdy;
    logic held;

    repeat (2) @(posedge clk);
    #1;
    chk_b("reset_en", lcd_en, 1'b0);
    chk_v("reset_data", int'(lcd_data), 0);
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: plain data byte from req0
    xfer(0, 1'b1, 8'h41, "t1", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t1_en_first", t_en0, 3);
    chk_v("t1_en_last", t_en1, 5);
    chk_v("t1_en_count", n_en, 3);
    chk_v("t1_done", t_done, 12);
    chk_v("t1_idle", t_idle, 13);

    // 2: clear command takes the long wait; same byte as data does not
    xfer(1, 1'b0, 8'h01, "t2a", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t2a_done", t_done, 16);
    chk_v("t2a_idle", t_idle, 17);
    xfer(1, 1'b1, 8'h01, "t2b", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t2b_done", t_done, 12);
    xfer(0, 1'b0, 8'h03, "t2c", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t2c_done", t_done, 16);
    xfer(0, 1'b0, 8'h00, "t2d", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t2d_done", t_done, 12);

    // 3: both streaming from reset alternate grants
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g_log.delete();
    fork
      stream(0, 3, 8'h30);
      stream(1, 3, 8'h60);
    join
    wait_idle("t3_idle");
    chk_v("t3_grants", g_log.size(), 6);
    for (int i = 0; i < 6 && i < g_log.size(); i++) chk_v("t3_order", g_log[i], i % 2);

    // 4: req0 raised during req1's WAIT is held off until the IDLE after done
    drive(1, 1'b1, 1'b1, 8'h55);
    wait_rdy(1, "t4_ready1");
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (7) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 8'h66);
    t_rdy = -1;
    held = 1'b1;
    for (int c = 8; c <= 30; c++) begin
      @(negedge clk);
      if (req0_ready) begin
        t_rdy = c;
        break;
      end
      if (lcd_data !== 8'h55) held = 1'b0;
      @(posedge clk); #1;
    end
    chk_v("t4_ready0_cycle", t_rdy, 13);
    chk_b("t4_data_held", held, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00);
    wait_idle("t4_idle");

    // 5: reset inside PULSE drops EN at once and loses the byte
    drive(0, 1'b1, 1'b1, 8'h41);
    wait_rdy(0, "t5_ready");
    drive(0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_b("t5_en_c3", lcd_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_b("t5_en_async", lcd_en, 1'b0);
    chk_v("t5_data_async", int'(lcd_data), 0);
    chk_b("t5_busy_async", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b1, 8'h42, "t5b", t_en0, t_en1, n_en, t_done, t_idle);
    chk_v("t5b_done", t_done, 12);

    // 6: a one-cycle req1 pulse while busy is ignored
    drive(0, 1'b1, 1'b1, 8'h77);
    wait_rdy(0, "t6_ready0");
    drive(0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 8'h99);
    @(negedge clk);
    chk_b("t6_no_ready1", req1_ready, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'h00);
    wait_idle("t6_idle");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_v("t6_data_kept", int'(lcd_data), 8'h77);
    chk_b("t6_still_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
